// File: rtl/router_pkg.sv
// Shared types for the 1-to-4 address-routed output port.
// Pure declarations; no logic, no latency, no flow control.
// Port addresses are 2 bits wide; onehot4 expands one to a 4-bit enable.
package router_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] port_addr_t;

    function automatic logic [NUM_PORTS-1:0] onehot4(port_addr_t addr);
        return 4'b0001 << addr;
    endfunction

endpackage

// File: rtl/router_demux.sv
// Steers one registered word onto one of four sink buses by its address.
// Purely combinational, zero latency; carries no flow control.
// Unselected buses, and all buses while din_en is low, are driven to zero.
module router_demux
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_en,
    input  port_addr_t            addr,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic [DATA_WIDTH-1:0] dout3
);

    logic [NUM_PORTS-1:0] sel;

    assign sel   = din_en ? onehot4(addr) : '0;
    assign dout0 = sel[0] ? din : '0;
    assign dout1 = sel[1] ? din : '0;
    assign dout2 = sel[2] ? din : '0;
    assign dout3 = sel[3] ? din : '0;

endmodule

// File: rtl/router_rr_scheduler.sv
// Round-robin scheduler sharing one address-routed output register among NUM_REQ requesters.
// Latency: one cycle from accept to dout*; sustains one word per cycle.
// Backpressure: ld = !out_valid | out_ready; ROUTER_RR_SCHED_STATS_EN adds grant counters.
module router_rr_scheduler
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [2*NUM_REQ-1:0]            req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [NUM_PORTS-1:0]            dout_en,
    output logic [DATA_WIDTH-1:0]           dout0,
    output logic [DATA_WIDTH-1:0]           dout1,
    output logic [DATA_WIDTH-1:0]           dout2,
    output logic [DATA_WIDTH-1:0]           dout3,
    output logic [CNT_WIDTH*NUM_REQ-1:0]    grant_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    port_addr_t            addr_arr [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign data_arr[r] = req_data[r*DATA_WIDTH +: DATA_WIDTH];
        assign addr_arr[r] = req_addr[2*r +: 2];
    end

    logic                  out_valid_q, out_valid_d;
    port_addr_t            out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;

    logic                  ld;
    logic                  accept;
    logic                  found;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W:0]        scan;
    logic [NUM_REQ-1:0]    gnt_oh;

    // Scan from rr_ptr upwards, wrapping past NUM_REQ-1; the first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan[PTR_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
    end

    assign ld        = !out_valid_q || out_ready;
    assign accept    = ld && found;
    assign gnt_oh    = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign req_ready = ld ? gnt_oh : '0;

    always_comb begin
        out_valid_d = ld ? found : out_valid_q;
        out_addr_d  = accept ? addr_arr[gnt_idx] : out_addr_q;
        out_data_d  = accept ? data_arr[gnt_idx] : out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout_en   = out_valid_q ? onehot4(out_addr_q) : '0;

    router_demux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_demux (
        .din    (out_data_q),
        .din_en (out_valid_q),
        .addr   (out_addr_q),
        .dout0  (dout0),
        .dout1  (dout1),
        .dout2  (dout2),
        .dout3  (dout3)
    );

`ifdef ROUTER_RR_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && gnt_oh[i] && !(&cnt_q[i])) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_cnt_out
        assign grant_cnt[r*CNT_WIDTH +: CNT_WIDTH] = cnt_q[r];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_router_rr_scheduler.sv
// Directed bench for router_rr_scheduler: reset, routing, round-robin order, stall, wrap, reset mid-stream.
// Define ROUTER_RR_SCHED_STATS_EN for both files to exercise the grant counters.
module tb_router_rr_scheduler;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NR-1:0]    req_valid;
    logic [2*NR-1:0]  req_addr;
    logic [DW*NR-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             out_ready;
    logic             out_valid;
    logic [3:0]       dout_en;
    logic [DW-1:0]    dout0, dout1, dout2, dout3;
    logic [CW*NR-1:0] grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ROUTER_RR_SCHED_STATS_EN
    localparam logic [CW-1:0] EXP_CNT2 = 16'd5;
`else
    localparam logic [CW-1:0] EXP_CNT2 = 16'd0;
`endif

    always #5 clk = ~clk;

    router_rr_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout_en   (dout_en),
        .dout0     (dout0),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .grant_cnt (grant_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dout_of(input int p);
        case (p)
            0:       return dout0;
            1:       return dout1;
            2:       return dout2;
            default: return dout3;
        endcase
    endfunction

    function automatic logic [DW-1:0] lane_data(input int i);
        return 32'h1000_0000 + DW'(i);
    endfunction

    // Port p must carry word w, and every other port must be idle at zero.
    task automatic chk_route(input string tag, input int p, input logic [DW-1:0] w);
        chk({tag, "_en"}, 64'(dout_en), 64'(4'b0001 << p));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_dout%0d", tag, k), 64'(dout_of(k)), (k == p) ? 64'(w) : 64'd0);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout_en",   64'(dout_en),   64'd0);
        chk("rst_dout0",     64'(dout0),     64'd0);
        chk("rst_dout1",     64'(dout1),     64'd0);
        chk("rst_dout2",     64'(dout2),     64'd0);
        chk("rst_dout3",     64'(dout3),     64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);

        // Single request: requester 1 to port 2
        resetn    = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b0010;
        req_addr  = 8'b0000_1000;
        req_data  = {32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0};
        #1;
        chk("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk_route("single", 2, 32'hA5A5_A5A5);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_en",    64'(dout_en),   64'd0);

        // All four continuously valid from a fresh pointer: grants 0,1,2,3,0
        resetn = 1'b0;
        tick();
        resetn    = 1'b1;
        req_addr  = 8'b11_10_01_00;
        req_data  = {lane_data(3), lane_data(2), lane_data(1), lane_data(0)};
        req_valid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("rr%0d_ready", s), 64'(req_ready), 64'(4'b0001 << (s % 4)));
            tick();
            chk_route($sformatf("rr%0d", s), s % 4, lane_data(s % 4));
        end

        // Stall for three cycles with word 0 held; pointer sits at 1
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall%0d_ready", s), 64'(req_ready), 64'd0);
            chk_route($sformatf("stall%0d", s), 0, lane_data(0));
            tick();
        end
        chk_route("stall_end", 0, lane_data(0));
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("unstall_valid", 64'(out_valid), 64'd1);
        chk_route("unstall", 1, lane_data(1));

        // Wrap: grant 2 moves the pointer to 3; lone req0 must still win and move it to 1
        req_valid = 4'b0100;
        #1;
        chk("wrap_pre_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("wrap_ready", 64'(req_ready), 64'b0001);
        tick();
        chk_route("wrap", 0, lane_data(0));
        req_valid = 4'b0011;
        #1;
        chk("wrap_ptr1_ready", 64'(req_ready), 64'b0010);
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);

        // Reset with a word in flight
        resetn    = 1'b0;
        req_valid = '0;
        tick();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_en",    64'(dout_en),   64'd0);
        chk("midrst_dout1", 64'(dout1),     64'd0);
        resetn    = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("midrst_ptr0_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        tick();

        // Grant counters: five grants to requester 2, then reset clears
        resetn = 1'b0;
        tick();
        resetn    = 1'b1;
        req_valid = 4'b0100;
        for (int s = 0; s < 5; s++) begin
            tick();
        end
        req_valid = '0;
        #1;
        chk("cnt0", 64'(grant_cnt[0*CW +: CW]), 64'd0);
        chk("cnt1", 64'(grant_cnt[1*CW +: CW]), 64'd0);
        chk("cnt2", 64'(grant_cnt[2*CW +: CW]), 64'(EXP_CNT2));
        chk("cnt3", 64'(grant_cnt[3*CW +: CW]), 64'd0);
        resetn = 1'b0;
        tick();
        chk("cnt_rst", 64'(grant_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
